// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared widths and legality rule for the NCO phase front end
//
// Purpose: default widths for the phase accumulator, output angle and rate
// divider, plus the rule that the quadrant bits plus the angle must fit in
// the accumulator.
// Ports: none (package).

package nco_pkg;

  localparam int unsigned PW_DEFAULT   = 32;
  localparam int unsigned AW_DEFAULT   = 16;
  localparam int unsigned DIVW_DEFAULT = 16;
  localparam int unsigned QUAD_W       = 2;

  typedef logic [QUAD_W-1:0] quadrant_t;

  // Two top phase bits select the quadrant; the rest must cover the angle.
  function automatic bit widths_legal(input int unsigned pw, input int unsigned aw);
    return (aw > 0) && (pw >= aw + QUAD_W);
  endfunction

endpackage

// File: rtl/nco_phase_quantizer.sv
// rtl/nco_phase_quantizer.sv - first-quadrant phase to angle rounding quantiser
//
// Purpose: reduce an IW-bit in-quadrant phase to AW bits, rounding half up.
// A rounding carry saturates to all-ones so the angle never wraps to zero
// and never spills into the quadrant.
// Ports:
//   phase_i  in  IW  phase within quadrant
//   angle_o  out AW  quantised angle

module phase_quantizer
  import nco_pkg::*;
#(
  parameter int unsigned IW = 30,
  parameter int unsigned AW = 16
) (
  input  logic [IW-1:0] phase_i,
  output logic [AW-1:0] angle_o
);

  if (IW == AW) begin : g_copy
    assign angle_o = phase_i;
  end else begin : g_round
    localparam int unsigned DW = IW - AW;
    logic [AW:0] rounded;

    // Adding the highest dropped bit implements round-half-up.
    assign rounded = {1'b0, phase_i[IW-1:DW]} + {{AW{1'b0}}, phase_i[DW-1]};
    assign angle_o = rounded[AW] ? {AW{1'b1}} : rounded[AW-1:0];
  end

endmodule

// File: rtl/nco_phase_gen.sv
// rtl/nco_phase_gen.sv - phase accumulator front end feeding the sin/cos stage
//
// Purpose: phase accumulator with a programmable sample-rate divider,
// phase-continuous frequency updates through a one-deep handshake, a
// restart command and a static output phase offset.
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   en_i, rate_div_i        run enable; tick every rate_div_i+1 enabled cycles
//   phase_offset_i          offset added to the accumulator at the output
//   cfg_valid_i/cfg_ready_o frequency word handshake, freq_i is the word
//   sync_i                  phase restart
//   valid_o, quadrant_o, angle_o, wrap_o  registered sample to sincos

module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int unsigned PW   = PW_DEFAULT,
  parameter int unsigned AW   = AW_DEFAULT,
  parameter int unsigned DIVW = DIVW_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [DIVW-1:0] rate_div_i,
  input  logic [PW-1:0]   phase_offset_i,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [PW-1:0]   freq_i,
  input  logic            sync_i,
  output logic            valid_o,
  output logic [1:0]      quadrant_o,
  output logic [AW-1:0]   angle_o,
  output logic            wrap_o
);

  if (!widths_legal(PW, AW)) begin : g_bad_widths
    always_ff @(posedge clk_i) $fatal(1, "nco_phase_gen: PW-2 must be >= AW");
  end

  logic [PW-1:0]   acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [PW-1:0]   freq_q, freq_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            pend_flag_q, pend_flag_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            valid_q, valid_d;
  quadrant_t       quad_q, quad_d;
  logic [AW-1:0]   angle_q, angle_d;
  logic            wrap_q, wrap_d;

  logic            tick;
  logic            accept;
  logic [PW-1:0]   phase;
  logic [PW:0]     acc_sum;
  logic [AW-1:0]   angle_quant;

  assign tick    = en_i & (div_q == rate_div_i);
  // The ready flag is simply "no word pending", so an accept can never
  // coincide with an apply; a word accepted on a tick waits for the next one.
  assign accept  = cfg_valid_i & ~pend_flag_q;
  assign phase   = acc_q + phase_offset_i;
  assign acc_sum = {1'b0, acc_q} + {1'b0, freq_q};

  phase_quantizer #(.IW(PW - 2), .AW(AW)) u_quant (
    .phase_i (phase[PW-3:0]),
    .angle_o (angle_quant)
  );

  always_comb begin
    acc_d       = acc_q;
    carry_d     = carry_q;
    freq_d      = freq_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    div_d       = div_q;
    valid_d     = 1'b0;
    quad_d      = quad_q;
    angle_d     = angle_q;
    wrap_d      = wrap_q;

    if (sync_i) begin
      acc_d   = '0;
      carry_d = 1'b0;
      div_d   = '0;
      if (pend_flag_q) begin
        freq_d      = pend_q;
        pend_flag_d = 1'b0;
      end
    end else if (tick) begin
      valid_d = 1'b1;
      quad_d  = phase[PW-1:PW-2];
      angle_d = angle_quant;
      wrap_d  = carry_q;
      // Increment uses the old word even on the tick that applies a new one.
      acc_d   = acc_sum[PW-1:0];
      carry_d = acc_sum[PW];
      div_d   = '0;
      if (pend_flag_q) begin
        freq_d      = pend_q;
        pend_flag_d = 1'b0;
      end
    end else if (en_i) begin
      div_d = div_q + 1'b1;
    end

    if (accept) begin
      pend_d      = freq_i;
      pend_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      carry_q     <= 1'b0;
      freq_q      <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      div_q       <= '0;
      valid_q     <= 1'b0;
      quad_q      <= '0;
      angle_q     <= '0;
      wrap_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      freq_q      <= freq_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      div_q       <= div_d;
      valid_q     <= valid_d;
      quad_q      <= quad_d;
      angle_q     <= angle_d;
      wrap_q      <= wrap_d;
    end
  end

  assign cfg_ready_o = ~pend_flag_q;
  assign valid_o     = valid_q;
  assign quadrant_o  = quad_q;
  assign angle_o     = angle_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// tb/tb_nco_phase_gen.sv - self-checking bench for nco_phase_gen

module tb_nco_phase_gen;

  localparam int PW   = 12;
  localparam int AW   = 8;
  localparam int DIVW = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            en_i;
  logic [DIVW-1:0] rate_div_i;
  logic [PW-1:0]   phase_offset_i;
  logic            cfg_valid_i;
  logic            cfg_ready_o;
  logic [PW-1:0]   freq_i;
  logic            sync_i;
  logic            valid_o;
  logic [1:0]      quadrant_o;
  logic [AW-1:0]   angle_o;
  logic            wrap_o;

  always #5 clk_i = ~clk_i;

  nco_phase_gen #(.PW(PW), .AW(AW), .DIVW(DIVW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .rate_div_i     (rate_div_i),
    .phase_offset_i (phase_offset_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .freq_i         (freq_i),
    .sync_i         (sync_i),
    .valid_o        (valid_o),
    .quadrant_o     (quadrant_o),
    .angle_o        (angle_o),
    .wrap_o         (wrap_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Angle from phase: low 10 bits rounded to the nearest multiple of 4,
  // clamped to the largest 8-bit angle.
  function automatic int quant(input int p);
    int r;
    r = ((p % 1024) + 2) / 4;
    return (r > 255) ? 255 : r;
  endfunction

  // Behavioural model, advanced once per rising edge from the inputs seen there.
  int m_acc, m_carry, m_freq, m_pendw, m_div, m_sum, m_p;
  bit m_pend, m_accept, m_live = 1'b0;
  bit e_valid;
  int e_quad, e_angle, e_wrap;

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_acc = 0; m_carry = 0; m_freq = 0; m_pendw = 0; m_div = 0;
      m_pend = 1'b0; e_valid = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      m_accept = cfg_valid_i && !m_pend;
      e_valid  = 1'b0;
      if (sync_i) begin
        m_acc = 0; m_carry = 0; m_div = 0;
        if (m_pend) begin m_freq = m_pendw; m_pend = 1'b0; end
      end else if (en_i && m_div == int'(rate_div_i)) begin
        m_p     = (m_acc + int'(phase_offset_i)) % 4096;
        e_valid = 1'b1;
        e_quad  = m_p / 1024;
        e_angle = quant(m_p);
        e_wrap  = m_carry;
        m_sum   = m_acc + m_freq;
        m_carry = (m_sum >= 4096) ? 1 : 0;
        m_acc   = m_sum % 4096;
        m_div   = 0;
        if (m_pend) begin m_freq = m_pendw; m_pend = 1'b0; end
      end else if (en_i) begin
        m_div = (m_div + 1) % 16;
      end
      if (m_accept) begin m_pendw = int'(freq_i); m_pend = 1'b1; end
    end
  end

  bit         cap_en = 1'b0;
  logic [9:0] cap[$];

  always @(negedge clk_i) begin
    if (m_live) begin
      chk("valid", valid_o, e_valid);
      chk("cfg_ready", cfg_ready_o, !m_pend);
      if (e_valid && valid_o) begin
        chk("quadrant", quadrant_o, e_quad);
        chk("angle", angle_o, e_angle);
        chk("wrap", wrap_o, e_wrap);
        if (cap_en) cap.push_back({quadrant_o, angle_o});
      end
    end
  end

  int s1q[6] = '{0, 0, 0, 0, 0, 1};
  int s1a[6] = '{0, 0, 'h40, 'h80, 'hC0, 0};

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; rate_div_i = '0; phase_offset_i = '0;
    cfg_valid_i = 1'b0; freq_i = '0; sync_i = 1'b0;
    repeat (2) step();
    chk("rst_valid", valid_o, 0);
    chk("rst_quadrant", quadrant_o, 0);
    chk("rst_angle", angle_o, 0);
    chk("rst_wrap", wrap_o, 0);
    chk("rst_ready", cfg_ready_o, 1);
    rst_ni = 1'b1;

    // Accept 0x100 while idle, then run every cycle.
    cfg_valid_i = 1'b1; freq_i = 12'h100;
    step();
    cfg_valid_i = 1'b0;
    chk("s1_ready_low", cfg_ready_o, 0);
    cap_en = 1'b1; en_i = 1'b1;
    repeat (8) step();
    cap_en = 1'b0;
    chk("s1_count", (cap.size() >= 6) ? 1 : 0, 1);
    for (int i = 0; i < 6 && i < cap.size(); i++) begin
      chk("s1_quadrant", cap[i][9:8], s1q[i]);
      chk("s1_angle", cap[i][7:0], s1a[i]);
    end

    // Quantiser boundaries with a zero frequency.
    rst_ni = 1'b0; step(); rst_ni = 1'b1;
    phase_offset_i = 12'h3FE; repeat (3) step();
    chk("sat_valid", valid_o, 1);
    chk("sat_quadrant", quadrant_o, 0);
    chk("sat_angle", angle_o, 'hFF);
    phase_offset_i = 12'h3FD; repeat (2) step();
    chk("rnd_angle", angle_o, 'hFF);
    phase_offset_i = 12'h401; repeat (2) step();
    chk("q1_quadrant", quadrant_o, 1);
    chk("q1_angle", angle_o, 0);

    // Divide by 3 with an enable gap mid-count.
    phase_offset_i = '0; rate_div_i = 4'd2;
    repeat (10) step();
    en_i = 1'b0; repeat (5) step();
    en_i = 1'b1; repeat (12) step();

    // 0x100 active, then 0x200 accepted on a tick cycle.
    rate_div_i = '0;
    cfg_valid_i = 1'b1; freq_i = 12'h100; step(); cfg_valid_i = 1'b0;
    repeat (3) step();
    cfg_valid_i = 1'b1; freq_i = 12'h200; step(); cfg_valid_i = 1'b0;
    repeat (5) step();

    // Frequency 0x400 for wrap flags, then a sync mid-stream.
    cfg_valid_i = 1'b1; freq_i = 12'h400; step(); cfg_valid_i = 1'b0;
    repeat (12) step();
    phase_offset_i = 12'h155;
    sync_i = 1'b1; step(); sync_i = 1'b0;
    chk("sync_no_valid", valid_o, 0);
    step();
    chk("sync_valid", valid_o, 1);
    chk("sync_quadrant", quadrant_o, 0);
    chk("sync_angle", angle_o, 'h55);

    // Reset while a word is pending.
    en_i = 1'b0;
    cfg_valid_i = 1'b1; freq_i = 12'h321; step(); cfg_valid_i = 1'b0;
    rst_ni = 1'b0; step(); rst_ni = 1'b1;
    chk("rst2_valid", valid_o, 0);
    chk("rst2_angle", angle_o, 0);
    chk("rst2_ready", cfg_ready_o, 1);
    en_i = 1'b1; repeat (4) step();
    chk("rst2_const_angle", angle_o, 'h55);
    step();
    chk("rst2_const_angle2", angle_o, 'h55);
    chk("rst2_const_quadrant", quadrant_o, 0);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      rst_ni      = ($urandom_range(0, 199) != 0);
      en_i        = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) rate_div_i = 4'($urandom_range(0, 3));
      cfg_valid_i = ($urandom_range(0, 3) == 0);
      freq_i      = 12'($urandom);
      sync_i      = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) phase_offset_i = 12'($urandom);
      step();
    end
    rst_ni = 1'b1; sync_i = 1'b0; cfg_valid_i = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
